cart_mem_ctrl: RTL and testbench

- Sits directly downstream of the MBC5 mapper.
- Takes the mapper's banked ROM/RAM address and active-low chip selects, plus the Game Boy bus strobes.
- Runs timed read/write cycles on the external parallel flash (ROM) and SRAM (cartridge RAM).
- Holds the read byte stable for the cartridge data bus.

---
 rtl/cart_mem_ctrl.sv | 131 +++++++++++++
 tb/tb_cart_mem_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_mem_ctrl.sv
// External flash/SRAM access sequencer behind the MBC5 mapper.
// The bus is edge-triggered: a falling gb_rd/gb_wr seen in IDLE starts one access, and done pulses once when it ends.
module cart_mem_ctrl #(
    parameter int RD_WAIT = 3,
    parameter int WR_WAIT = 2
) (
    input  logic        gb_clk,
    input  logic        gb_rst,
    input  logic [13:0] gb_a,
    input  logic [7:0]  gb_d,
    input  logic        gb_rd,
    input  logic        gb_wr,
    input  logic        rom_cs,
    input  logic        ram_cs,
    input  logic [8:0]  rom_a,
    input  logic [3:0]  ram_a,
    output logic [22:0] mem_a,
    input  logic [7:0]  mem_d_i,
    output logic [7:0]  mem_d_o,
    output logic        mem_d_oe,
    output logic        flash_ce_n,
    output logic        sram_ce_n,
    output logic        mem_oe_n,
    output logic        mem_we_n,
    output logic [7:0]  gb_q,
    output logic        busy,
    output logic        done,
    output logic [2:0]  fsm_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RSETUP = 3'd1,
        READ   = 3'd2,
        WSETUP = 3'd3,
        WRITE  = 3'd4,
        WHOLD  = 3'd5
    } state_t;

    state_t      state, state_nx;
    logic        rd_q, wr_q;
    logic        tgt_ram;
    logic [3:0]  cnt;
    logic        rd_req, wr_req, last_rd;

    // A read beats a simultaneous write; writes under rom_cs go to the mapper, not memory.
    assign rd_req  = (state == IDLE) && rd_q && !gb_rd && (!rom_cs || !ram_cs);
    assign wr_req  = (state == IDLE) && !rd_req && wr_q && !gb_wr && rom_cs && !ram_cs;
    assign last_rd = (state == READ) && (cnt == 4'd0);
    assign fsm_state = state;

    always_ff @(posedge gb_clk or negedge gb_rst) begin
        if (!gb_rst) begin
            state   <= IDLE;
            rd_q    <= 1'b1;
            wr_q    <= 1'b1;
            cnt     <= 4'd0;
            tgt_ram <= 1'b0;
            mem_a   <= 23'd0;
            mem_d_o <= 8'd0;
            gb_q    <= 8'hFF;
            done    <= 1'b0;
        end else begin
            state <= state_nx;
            rd_q  <= gb_rd;
            wr_q  <= gb_wr;
            done  <= last_rd || (state == WHOLD);
            if (rd_req) begin
                tgt_ram <= rom_cs;
                mem_a   <= rom_cs ? {6'b0, ram_a, gb_a[12:0]} : {rom_a, gb_a};
            end else if (wr_req) begin
                tgt_ram <= 1'b1;
                mem_a   <= {6'b0, ram_a, gb_a[12:0]};
                mem_d_o <= gb_d;
            end
            if (last_rd)
                gb_q <= mem_d_i;
            case (state)
                RSETUP:      cnt <= 4'(RD_WAIT - 1);
                WSETUP:      cnt <= 4'(WR_WAIT - 1);
                READ, WRITE: if (cnt != 4'd0) cnt <= cnt - 4'd1;
                default:     ;
            endcase
        end
    end

    always_comb begin
        state_nx   = state;
        flash_ce_n = 1'b1;
        sram_ce_n  = 1'b1;
        mem_oe_n   = 1'b1;
        mem_we_n   = 1'b1;
        mem_d_oe   = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (rd_req)      state_nx = RSETUP;
                else if (wr_req) state_nx = WSETUP;
            end
            RSETUP: begin
                state_nx   = READ;
                flash_ce_n = tgt_ram;
                sram_ce_n  = !tgt_ram;
            end
            READ: begin
                if (cnt == 4'd0) state_nx = IDLE;
                flash_ce_n = tgt_ram;
                sram_ce_n  = !tgt_ram;
                mem_oe_n   = 1'b0;
            end
            WSETUP: begin
                state_nx  = WRITE;
                sram_ce_n = 1'b0;
                mem_d_oe  = 1'b1;
            end
            WRITE: begin
                if (cnt == 4'd0) state_nx = WHOLD;
                sram_ce_n = 1'b0;
                mem_d_oe  = 1'b1;
                mem_we_n  = 1'b0;
            end
            WHOLD: begin
                state_nx  = IDLE;
                sram_ce_n = 1'b0;
                mem_d_oe  = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cart_mem_ctrl.sv
// Bench for cart_mem_ctrl: offset-based transaction model, per-cycle compare, directed cases then random traffic.
module tb_cart_mem_ctrl;
    localparam int RD_WAIT = 3;
    localparam int WR_WAIT = 2;

    logic        gb_clk = 1'b0;
    logic        gb_rst = 1'b1;
    logic [13:0] gb_a = '0;
    logic [7:0]  gb_d = '0;
    logic        gb_rd = 1'b1, gb_wr = 1'b1, rom_cs = 1'b1, ram_cs = 1'b1;
    logic [8:0]  rom_a = '0;
    logic [3:0]  ram_a = '0;
    logic [7:0]  mem_d_i = '0;
    logic [22:0] mem_a;
    logic [7:0]  mem_d_o, gb_q;
    logic        mem_d_oe, flash_ce_n, sram_ce_n, mem_oe_n, mem_we_n, busy, done;
    logic [2:0]  fsm_state;

    cart_mem_ctrl #(.RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
        .gb_clk(gb_clk), .gb_rst(gb_rst), .gb_a(gb_a), .gb_d(gb_d),
        .gb_rd(gb_rd), .gb_wr(gb_wr), .rom_cs(rom_cs), .ram_cs(ram_cs),
        .rom_a(rom_a), .ram_a(ram_a), .mem_a(mem_a), .mem_d_i(mem_d_i),
        .mem_d_o(mem_d_o), .mem_d_oe(mem_d_oe), .flash_ce_n(flash_ce_n),
        .sram_ce_n(sram_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
        .gb_q(gb_q), .busy(busy), .done(done), .fsm_state(fsm_state)
    );

    // clock / cycle count
    always #5 gb_clk = ~gb_clk;
    int cyc = 0;
    always @(posedge gb_clk) cyc++;

    int checks = 0, errors = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_k counts cycles since the accepting edge (0 = idle).
    int          m_k = 0;
    bit          m_is_rd = 0, m_ram = 0, m_done = 0, m_done_rd = 0;
    logic [22:0] m_addr = '0;
    logic [7:0]  m_wdata = '0, m_gbq = 8'hFF;
    logic        m_rd_prev = 1'b1, m_wr_prev = 1'b1;
    logic [7:0]  exp_q[$];

    always @(posedge gb_clk or negedge gb_rst) begin
        int a;
        if (!gb_rst) begin
            m_k = 0; m_gbq = 8'hFF; m_addr = '0; m_wdata = '0;
            m_rd_prev = 1'b1; m_wr_prev = 1'b1; m_done = 0; m_done_rd = 0;
            exp_q.delete();
        end else begin
            m_done = 0;
            m_done_rd = 0;
            if (m_k != 0) begin
                if (m_is_rd && m_k == RD_WAIT + 1) m_gbq = mem_d_i;
                if (m_k == (m_is_rd ? RD_WAIT + 1 : WR_WAIT + 2)) begin
                    m_done = 1;
                    m_done_rd = m_is_rd;
                    if (m_is_rd) exp_q.push_back(m_gbq);
                    m_k = 0;
                end else m_k++;
            end else if (m_rd_prev && !gb_rd && (!rom_cs || !ram_cs)) begin
                m_k = 1; m_is_rd = 1; m_ram = rom_cs;
                a = rom_cs ? int'(ram_a) * 8192 + int'(gb_a) % 8192 : int'(rom_a) * 16384 + int'(gb_a);
                m_addr = a[22:0];
            end else if (m_wr_prev && !gb_wr && rom_cs && !ram_cs) begin
                m_k = 1; m_is_rd = 0; m_ram = 1;
                a = int'(ram_a) * 8192 + int'(gb_a) % 8192;
                m_addr = a[22:0];
                m_wdata = gb_d;
            end
            m_rd_prev = gb_rd;
            m_wr_prev = gb_wr;
        end
    end

    // per-cycle compare plus activity counters for the directed cases
    int flash_lo, sram_lo, oe_lo, we_lo, doe_hi, busy_hi, overlap, done_cyc;

    task automatic clear_counts();
        flash_lo = 0; sram_lo = 0; oe_lo = 0; we_lo = 0;
        doe_hi = 0; busy_hi = 0; overlap = 0; done_cyc = -1;
    endtask

    always @(negedge gb_clk) begin
        bit act;
        logic [7:0] e;
        if (chk_en) begin
            act = (m_k != 0);
            chk("busy", busy, act);
            chk("flash_ce_n", flash_ce_n, !(act && m_is_rd && !m_ram));
            chk("sram_ce_n", sram_ce_n, !(act && (!m_is_rd || m_ram)));
            chk("mem_oe_n", mem_oe_n, !(m_is_rd && m_k >= 2));
            chk("mem_we_n", mem_we_n, !(!m_is_rd && m_k >= 2 && m_k <= WR_WAIT + 1));
            chk("mem_d_oe", mem_d_oe, act && !m_is_rd);
            chk("done", done, m_done);
            chk("mem_a", mem_a, m_addr);
            chk("mem_d_o", mem_d_o, m_wdata);
            chk("gb_q", gb_q, m_gbq);
            chk("one_ce", flash_ce_n | sram_ce_n, 1);
            chk("oe_we_excl", mem_oe_n | mem_we_n, 1);
            if (m_done_rd && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_read_data", gb_q, e);
            end
            flash_lo += !flash_ce_n;
            sram_lo  += !sram_ce_n;
            oe_lo    += !mem_oe_n;
            we_lo    += !mem_we_n;
            doe_hi   += mem_d_oe;
            busy_hi  += busy;
            overlap  += (!flash_ce_n && !sram_ce_n);
            if (done) done_cyc = cyc;
        end
    end

    // drivers
    task automatic step(input int n);
        repeat (n) begin @(posedge gb_clk); #2; end
    endtask

    task automatic idle_bus();
        gb_rd = 1'b1; gb_wr = 1'b1; rom_cs = 1'b1; ram_cs = 1'b1;
    endtask

    initial begin
        int req_cyc;
        clear_counts();
        #1 gb_rst = 1'b0;
        #1 chk_en = 1;
        step(3);
        gb_rst = 1'b1;
        clear_counts();
        step(20);
        chk("rst_gb_q", gb_q, 8'hFF);
        chk("rst_busy_cycles", busy_hi, 0);
        chk("rst_ce_cycles", flash_lo + sram_lo + oe_lo + we_lo, 0);
        chk("rst_mem_a", mem_a, 23'h0);

        // ROM read
        rom_cs = 1'b0; rom_a = 9'h005; gb_a = 14'h1234; mem_d_i = 8'h3C;
        clear_counts();
        gb_rd = 1'b0;
        step(1); req_cyc = cyc;
        step(6);
        idle_bus(); step(2);
        chk("rom_rd_addr", mem_a, 23'h015234);
        chk("rom_rd_data", gb_q, 8'h3C);
        chk("rom_rd_ce_cycles", flash_lo, 4);
        chk("rom_rd_oe_cycles", oe_lo, 3);
        chk("rom_rd_latency", done_cyc - req_cyc, 4);
        chk("rom_rd_no_we", we_lo, 0);

        // RAM write
        ram_cs = 1'b0; ram_a = 4'h3; gb_a = 14'h0010; gb_d = 8'hA5;
        clear_counts();
        gb_wr = 1'b0;
        step(1); req_cyc = cyc;
        step(6);
        idle_bus(); step(2);
        chk("ram_wr_addr", mem_a, 23'h006010);
        chk("ram_wr_data", mem_d_o, 8'hA5);
        chk("ram_wr_we_cycles", we_lo, 2);
        chk("ram_wr_doe_cycles", doe_hi, 4);
        chk("ram_wr_sram_cycles", sram_lo, 4);
        chk("ram_wr_overlap", overlap, 0);
        chk("ram_wr_latency", done_cyc - req_cyc, 4);
        chk("ram_wr_gb_q_kept", gb_q, 8'h3C);

        // mapper register write
        rom_cs = 1'b0; ram_cs = 1'b1; gb_d = 8'h11;
        clear_counts();
        gb_wr = 1'b0;
        step(6);
        idle_bus(); step(2);
        chk("map_wr_busy", busy_hi, 0);
        chk("map_wr_ce", flash_lo + sram_lo + we_lo, 0);

        // simultaneous read and write edges
        ram_cs = 1'b0; ram_a = 4'h1; gb_a = 14'h0222; gb_d = 8'h99; mem_d_i = 8'h5A;
        clear_counts();
        gb_rd = 1'b0; gb_wr = 1'b0;
        step(7);
        idle_bus(); step(2);
        chk("sim_no_we", we_lo, 0);
        chk("sim_oe_cycles", oe_lo, 3);
        chk("sim_sram_cycles", sram_lo, 4);
        chk("sim_no_doe", doe_hi, 0);
        chk("sim_rd_data", gb_q, 8'h5A);
        chk("sim_addr", mem_a, 23'h002222);

        // reset during READ cycle 2, then a normal read
        rom_cs = 1'b0; rom_a = 9'h1FF; gb_a = 14'h3FFF; mem_d_i = 8'h77;
        gb_rd = 1'b0;
        step(3);
        gb_rst = 1'b0;
        #1;
        chk("midrst_flash", flash_ce_n, 1);
        chk("midrst_oe", mem_oe_n, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_gb_q", gb_q, 8'hFF);
        chk("midrst_mem_a", mem_a, 23'h0);
        idle_bus();
        step(2);
        gb_rst = 1'b1;
        step(1);
        rom_cs = 1'b0; rom_a = 9'h002; gb_a = 14'h0001; mem_d_i = 8'hC3;
        clear_counts();
        gb_rd = 1'b0;
        step(1); req_cyc = cyc;
        step(6);
        idle_bus(); step(2);
        chk("post_rst_addr", mem_a, 23'h008001);
        chk("post_rst_data", gb_q, 8'hC3);
        chk("post_rst_latency", done_cyc - req_cyc, 4);
        chk("post_rst_ce_cycles", flash_lo, 4);

        // random traffic
        repeat (3000) begin
            gb_rd   = ($urandom_range(0, 2) != 0);
            gb_wr   = ($urandom_range(0, 2) != 0);
            rom_cs  = ($urandom_range(0, 2) != 0);
            ram_cs  = ($urandom_range(0, 3) == 0);
            gb_a    = 14'($urandom);
            gb_d    = 8'($urandom);
            rom_a   = 9'($urandom);
            ram_a   = 4'($urandom);
            mem_d_i = 8'($urandom);
            if (!gb_rst) gb_rst = 1'b1;
            else if ($urandom_range(0, 299) == 0) gb_rst = 1'b0;
            step(1);
        end
        gb_rst = 1'b1;
        idle_bus();
        step(10);
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
